// File: rtl/apb_pmem_slave.sv
// Parametrised APB4 leaf memory slave: per-direction wait states, read-only word window,
// out-of-range / misalignment error responses and a saturating error counter.
module apb_pmem_slave #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int READ_WAIT     = 1,
    parameter int WRITE_WAIT    = 3,
    parameter int RO_LO         = 0,
    parameter int RO_HI         = 15,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_WIDTH-1:0]      PADDR,
    input  logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH/8-1:0]    PSTRB,
    output logic [DATA_WIDTH-1:0]      PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [ERR_CNT_WIDTH-1:0]   err_count
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NB);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1'b1);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("apb_pmem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (READ_WAIT < 0 || READ_WAIT > 15 || WRITE_WAIT < 0 || WRITE_WAIT > 15) begin : g_bad_wait
        $error("apb_pmem_slave: READ_WAIT and WRITE_WAIT must be within 0..15");
    end
    if (DEPTH < 1 || DEPTH > 2 ** IDX_W) begin : g_bad_depth
        $error("apb_pmem_slave: DEPTH does not fit the word address space");
    end
    if (RO_LO < 0 || RO_HI < 0) begin : g_bad_ro
        $error("apb_pmem_slave: RO_LO and RO_HI must be non-negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // state_r only needs to remember ACCESS; the SETUP phase is recognised from the bus in
    // the same cycle so that a zero-wait transfer completes in two cycles.
    state_t                   state_r;
    state_t                   phase_s;
    logic [3:0]               wait_cnt_r;
    logic [IDX_W-1:0]         idx_s;
    logic [32:0]              idx_ext_s;
    logic [MEM_AW-1:0]        mem_idx_s;
    logic                     misalign_s;
    logic                     oor_s;
    logic                     ro_hit_s;
    logic                     err_s;
    logic                     pready_s;
    logic                     commit_s;
    logic [DATA_WIDTH-1:0]    mem_r [DEPTH];

    assign idx_s     = PADDR[ADDR_WIDTH-1:LSB];
    assign idx_ext_s = 33'(idx_s);
    assign mem_idx_s = idx_s[MEM_AW-1:0];

    if (LSB == 0) begin : g_byte_wide
        assign misalign_s = 1'b0;
    end else begin : g_multi_byte
        assign misalign_s = |PADDR[LSB-1:0];
    end

    assign oor_s    = (idx_ext_s >= 33'(DEPTH));
    assign ro_hit_s = (idx_ext_s >= 33'(RO_LO)) && (idx_ext_s <= 33'(RO_HI));
    assign err_s    = misalign_s || oor_s || (PWRITE && ro_hit_s);

    assign pready_s = (state_r == ST_ACCESS) && ((wait_cnt_r == 4'd0) || err_s);
    assign commit_s = pready_s && PWRITE && !err_s;

    assign PREADY  = pready_s;
    assign PSLVERR = pready_s && err_s;
    assign PRDATA  = (pready_s && !PWRITE && !err_s) ? mem_r[mem_idx_s] : {DATA_WIDTH{1'b0}};

    // Current bus phase as seen by the slave.
    always_comb begin
        if (state_r == ST_ACCESS) begin
            phase_s = ST_ACCESS;
        end else if (PSEL && !PENABLE) begin
            phase_s = ST_SETUP;
        end else begin
            phase_s = ST_IDLE;
        end
    end

    // Transfer FSM and wait-state counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            case (phase_s)
                ST_SETUP: begin
                    state_r    <= ST_ACCESS;
                    wait_cnt_r <= PWRITE ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
                end
                ST_ACCESS: begin
                    if (pready_s || !PSEL) begin
                        // Completion, or master dropped PSEL mid-wait (abort, nothing committed).
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= 4'd0;
                    end else begin
                        state_r    <= ST_ACCESS;
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of error completions.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_count <= {ERR_CNT_WIDTH{1'b0}};
        end else if (pready_s && err_s && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
        end
    end

    // Byte-lane write port; memory contents are deliberately not reset.
    always_ff @(posedge PCLK) begin
        if (commit_s) begin
            for (int i = 0; i < NB; i++) begin
                if (PSTRB[i]) begin
                    mem_r[mem_idx_s][i*8 +: 8] <= PWDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule
